spi_fnd_receiver: RTL and testbench

SPI slave (mode 0, MSB first) that receives the 2-byte counter frame from the counter/num_sender stage: byte 0 = count/100, byte 1 = count%100.
- Validates the frame, splits each byte into BCD tens/ones, and drives a 4-digit time-multiplexed FND (7-segment) display.
- Sits directly downstream of the counter's SPI master, on the display board side.

---
 rtl/fnd_pkg.sv | 42 ++++
 rtl/fnd_scan_ctrl.sv | 70 +++++++
 rtl/spi_fnd_receiver.sv | 128 ++++++++++++
 tb/tb_spi_fnd_receiver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared types and constants for the SPI-fed 4-digit 7-segment display.
// Segment codes are active low, bit order {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    OVR  = 2'd2
  } rx_state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Non-BCD codes cannot occur after the range check; show blank if they do.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan of four 7-segment digits from two 0..99 values.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros (digit0 always lit).
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] disp_hi,
  input  logic [7:0] disp_lo,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDXW = $clog2(NUM_DIGITS);

  logic [PW-1:0]   presc_q;
  logic [IDXW-1:0] idx_q;
  logic [3:0]      digit [NUM_DIGITS];
  logic [3:0]      blank;
  logic [3:0]      cur_digit;
  logic            cur_blank;
  logic [7:0]      fnd_data_d;
  logic [3:0]      fnd_com_d;

  assign digit[3] = 4'(disp_hi / 8'd10);
  assign digit[2] = 4'(disp_hi % 8'd10);
  assign digit[1] = 4'(disp_lo / 8'd10);
  assign digit[0] = 4'(disp_lo % 8'd10);

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank only if it and every digit to its left are zero.
  assign blank[3] = (digit[3] == 4'd0);
  assign blank[2] = blank[3] && (digit[2] == 4'd0);
  assign blank[1] = blank[2] && (digit[1] == 4'd0);
  assign blank[0] = 1'b0;
`else
  assign blank = 4'b0000;
`endif

  // Select the digit and its blank flag for the current scan slot.
  always_comb begin
    cur_digit = digit[idx_q];
    cur_blank = blank[idx_q];
    fnd_data_d = cur_blank ? SEG_BLANK : bcd_to_seg(cur_digit);
    fnd_com_d  = ~(4'b0001 << idx_q);
  end

  // Prescaler, digit index and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      fnd_com  <= 4'b1110;
      fnd_data <= SEG_0;
    end else begin
      if (presc_q == PW'(REFRESH_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= idx_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      fnd_com  <= fnd_com_d;
      fnd_data <= fnd_data_d;
    end
  end

endmodule

// File: rtl/spi_fnd_receiver.sv
// SPI mode-0 slave receiving a {count/100, count%100} frame and driving
// a 4-digit FND. Optional macro LEADING_ZERO_BLANK_EN (see fnd_scan_ctrl).
//
//   state | meaning
//   IDLE  | waiting for ss falling edge
//   RX    | shifting bits in, up to two bytes
//   OVR   | third byte started; ignore sclk until ss rises
module spi_fnd_receiver
  import fnd_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int MAX_VAL     = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data,
  output logic       frame_valid,
  output logic       frame_err
);

  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [2:0] ss_q;
  logic       sclk_rise, ss_fall, ss_rise, ss_low, mosi_s;

  rx_state_t  state_q;
  logic [2:0] bit_cnt_q;
  logic [1:0] byte_cnt_q;
  logic [7:0] shift_q, hi_buf_q, lo_buf_q;
  logic [7:0] disp_hi_q, disp_lo_q;
  logic       commit_ok;

  // Two-flop synchronisers plus one extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
      ss_q   <= 3'b111;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
      ss_q   <= {ss_q[1:0], ss};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign ss_low    = ~ss_q[1];
  assign mosi_s    = mosi_q[1];

  assign commit_ok = (state_q == RX) && (byte_cnt_q == 2'd2) && (bit_cnt_q == 3'd0) &&
                     (hi_buf_q <= 8'(MAX_VAL)) && (lo_buf_q <= 8'(MAX_VAL));

  // Receive FSM, frame evaluation and display registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      hi_buf_q    <= '0;
      lo_buf_q    <= '0;
      disp_hi_q   <= '0;
      disp_lo_q   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (ss_rise) begin
        // End of transfer takes priority over any coincident sclk edge.
        state_q <= IDLE;
        if (commit_ok) begin
          disp_hi_q   <= hi_buf_q;
          disp_lo_q   <= lo_buf_q;
          frame_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (ss_fall) begin
              state_q    <= RX;
              bit_cnt_q  <= '0;
              byte_cnt_q <= '0;
              shift_q    <= '0;
            end
          end
          RX: begin
            if (sclk_rise && ss_low) begin
              if (byte_cnt_q == 2'd2) begin
                state_q <= OVR;
              end else begin
                shift_q   <= {shift_q[6:0], mosi_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                  if (byte_cnt_q == 2'd0) hi_buf_q <= {shift_q[6:0], mosi_s};
                  else                    lo_buf_q <= {shift_q[6:0], mosi_s};
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                end
              end
            end
          end
          OVR:     state_q <= OVR;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  fnd_scan_ctrl #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .disp_hi (disp_hi_q),
    .disp_lo (disp_lo_q),
    .fnd_com (fnd_com),
    .fnd_data(fnd_data)
  );

endmodule

// File: tb/tb_spi_fnd_receiver.sv
// Directed bench for spi_fnd_receiver: SPI frames in, scanned segments out.
module tb_spi_fnd_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ss = 1'b1;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;
  logic       frame_valid;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  spi_fnd_receiver #(
    .REFRESH_DIV(4),
    .MAX_VAL    (99)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .mosi       (mosi),
    .ss         (ss),
    .fnd_com    (fnd_com),
    .fnd_data   (fnd_data),
    .frame_valid(frame_valid),
    .frame_err  (frame_err)
  );

  always @(negedge clk) begin
    if (frame_valid === 1'b1) vld_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic ss_start();
    ss = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_end();
    repeat (4) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // sclk = clk/8: data changes while sclk low, sampled on the rising edge.
  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  // Waits (bounded) until the given digit is selected and returns its segments.
  task automatic wait_slot(input logic [3:0] com, output logic [7:0] data, output bit ok);
    ok = 1'b0;
    data = 8'h00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fnd_com === com) begin
        ok = 1'b1;
        data = fnd_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    bit ok;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (fnd_com !== 4'b1110) begin errors++; $display("FAIL reset_com got %b want 1110", fnd_com); end
    checks++;
    if (fnd_data !== 8'hC0) begin errors++; $display("FAIL reset_data got %h want C0", fnd_data); end
    for (int s = 0; s < 4; s++) begin
      wait_slot(~(4'b0001 << s), d, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_scan slot %0d timeout", s); end
      else if (d !== 8'hC0) begin errors++; $display("FAIL reset_scan slot %0d got %h want C0", s, d); end
    end
    checks++;
    if (vld_cnt !== 0 || err_cnt !== 0) begin
      errors++; $display("FAIL reset_pulses got valid=%0d err=%0d want 0 0", vld_cnt, err_cnt);
    end
  endtask

  task automatic test_frame_1234();
    logic [7:0] d;
    logic [7:0] exp [4];
    bit ok;
    int v0, e0;
    exp[0] = 8'h99; exp[1] = 8'hB0; exp[2] = 8'hA4; exp[3] = 8'hF9;
    v0 = vld_cnt; e0 = err_cnt;
    ss_start(); spi_bits(8'd12, 8); spi_bits(8'd34, 8); ss_end();
    checks++;
    if (vld_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL frame1234_pulses got valid=%0d err=%0d want 1 0", vld_cnt - v0, err_cnt - e0);
    end
    for (int s = 0; s < 4; s++) begin
      wait_slot(~(4'b0001 << s), d, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL frame1234 slot %0d timeout", s); end
      else if (d !== exp[s]) begin errors++; $display("FAIL frame1234 slot %0d got %h want %h", s, d, exp[s]); end
    end
  endtask

  task automatic test_bad_frames();
    logic [7:0] d;
    logic [7:0] exp [4];
    bit ok;
    int v0, e0;
    exp[0] = 8'h99; exp[1] = 8'hB0; exp[2] = 8'hA4; exp[3] = 8'hF9;
    // short frame: one byte only
    v0 = vld_cnt; e0 = err_cnt;
    ss_start(); spi_bits(8'd56, 8); ss_end();
    checks++;
    if (vld_cnt - v0 !== 0 || err_cnt - e0 !== 1) begin
      errors++; $display("FAIL short_frame got valid=%0d err=%0d want 0 1", vld_cnt - v0, err_cnt - e0);
    end
    // out of range high byte
    v0 = vld_cnt; e0 = err_cnt;
    ss_start(); spi_bits(8'd150, 8); spi_bits(8'd0, 8); ss_end();
    checks++;
    if (vld_cnt - v0 !== 0 || err_cnt - e0 !== 1) begin
      errors++; $display("FAIL range_frame got valid=%0d err=%0d want 0 1", vld_cnt - v0, err_cnt - e0);
    end
    // boundary: 100 in the low byte also rejected
    v0 = vld_cnt; e0 = err_cnt;
    ss_start(); spi_bits(8'd1, 8); spi_bits(8'd100, 8); ss_end();
    checks++;
    if (vld_cnt - v0 !== 0 || err_cnt - e0 !== 1) begin
      errors++; $display("FAIL range_lo got valid=%0d err=%0d want 0 1", vld_cnt - v0, err_cnt - e0);
    end
    // overrun: three bytes
    v0 = vld_cnt; e0 = err_cnt;
    ss_start(); spi_bits(8'd1, 8); spi_bits(8'd2, 8); spi_bits(8'd3, 8); ss_end();
    checks++;
    if (vld_cnt - v0 !== 0 || err_cnt - e0 !== 1) begin
      errors++; $display("FAIL overrun got valid=%0d err=%0d want 0 1", vld_cnt - v0, err_cnt - e0);
    end
    // ss pulse with no clocks
    v0 = vld_cnt; e0 = err_cnt;
    ss_start(); ss_end();
    checks++;
    if (vld_cnt - v0 !== 0 || err_cnt - e0 !== 1) begin
      errors++; $display("FAIL empty_frame got valid=%0d err=%0d want 0 1", vld_cnt - v0, err_cnt - e0);
    end
    for (int s = 0; s < 4; s++) begin
      wait_slot(~(4'b0001 << s), d, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bad_hold slot %0d timeout", s); end
      else if (d !== exp[s]) begin errors++; $display("FAIL bad_hold slot %0d got %h want %h", s, d, exp[s]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    bit ok;
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    ss_start(); spi_bits(8'd12, 8); spi_bits(8'd34, 5);
    reset = 1'b1;
    ss = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (vld_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL midreset_pulses got valid=%0d err=%0d want 0 0", vld_cnt - v0, err_cnt - e0);
    end
    wait_slot(4'b1110, d, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_zero timeout"); end
    else if (d !== 8'hC0) begin errors++; $display("FAIL midreset_zero got %h want C0", d); end
    v0 = vld_cnt; e0 = err_cnt;
    ss_start(); spi_bits(8'd99, 8); spi_bits(8'd99, 8); ss_end();
    checks++;
    if (vld_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL frame9999_pulses got valid=%0d err=%0d want 1 0", vld_cnt - v0, err_cnt - e0);
    end
    for (int s = 0; s < 4; s++) begin
      wait_slot(~(4'b0001 << s), d, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL frame9999 slot %0d timeout", s); end
      else if (d !== 8'h90) begin errors++; $display("FAIL frame9999 slot %0d got %h want 90", s, d); end
    end
  endtask

  task automatic test_leading_zero();
    logic [7:0] d;
    logic [7:0] exp [4];
    bit ok;
    int v0;
`ifdef LEADING_ZERO_BLANK_EN
    exp[0] = 8'hF8; exp[1] = 8'hFF; exp[2] = 8'hFF; exp[3] = 8'hFF;
`else
    exp[0] = 8'hF8; exp[1] = 8'hC0; exp[2] = 8'hC0; exp[3] = 8'hC0;
`endif
    v0 = vld_cnt;
    ss_start(); spi_bits(8'd0, 8); spi_bits(8'd7, 8); ss_end();
    checks++;
    if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL frame0007_valid got %0d want 1", vld_cnt - v0); end
    for (int s = 0; s < 4; s++) begin
      wait_slot(~(4'b0001 << s), d, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL frame0007 slot %0d timeout", s); end
      else if (d !== exp[s]) begin errors++; $display("FAIL frame0007 slot %0d got %h want %h", s, d, exp[s]); end
    end
  endtask

  initial begin
    test_reset();
    test_frame_1234();
    test_bad_frames();
    test_reset_midframe();
    test_leading_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
